// File: rtl/ysyx_23060240_csr_pkg.sv
// Shared CSR addresses, operation encodings, cause codes and mstatus bit positions
// for the machine-mode CSR / trap unit.
package ysyx_23060240_csr_pkg;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MIE_MEIE       = 11;
  localparam int unsigned MIP_MEIP       = 11;

  localparam logic [4:0] CAUSE_ECALL_M   = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_EXT_M = 5'd11;

  // RS/RC with a zero operand are read-only accesses and must not write.
  function automatic logic csr_op_writes(csr_op_e op, logic wdata_zero);
    return (op == CsrOpRw) || (((op == CsrOpRs) || (op == CsrOpRc)) && !wdata_zero);
  endfunction

endpackage

// File: rtl/ysyx_23060240_csr_counter.sv
// 64-bit mcycle counter: free-running increment with wrap, CSR writes to either half win.
module ysyx_23060240_csr_counter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_lo_i,
  input  logic            wr_hi_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [63:0]     value_o
);

  logic [63:0] cnt_q, cnt_d;
  logic [63:0] wdata_ext;

  assign wdata_ext = 64'(wdata_i);

  always_comb begin
    cnt_d = cnt_q + 64'd1;
    if (wr_lo_i) begin
      // On a 64-bit core the low address covers the whole counter.
      cnt_d[31:0]  = wdata_ext[31:0];
      cnt_d[63:32] = (XLEN > 32) ? wdata_ext[63:32] : cnt_q[63:32];
    end else if (wr_hi_i) begin
      cnt_d = {wdata_ext[31:0], cnt_q[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/ysyx_23060240_csr_trap.sv
// Machine-mode CSR file with ecall / external-interrupt trap entry and mret.
// Define CSR_MCYCLE_EN to add the 64-bit mcycle counter (0xB00 / 0xB80).
module ysyx_23060240_csr_trap
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            ecall,
  input  logic            mret,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            trap_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal
);

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_meie_q, mie_meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [XLEN-1:0] mstatus_val, mie_val, mip_val;
  logic [XLEN-1:0] csr_old, wr_val;
  logic            csr_hit, csr_we, irq_pend, mret_taken;

`ifdef CSR_MCYCLE_EN
  logic [63:0] cnt_value;
  logic        cnt_wr_lo, cnt_wr_hi;
`endif

  always_comb begin
    mstatus_val                                   = '0;
    mstatus_val[MSTATUS_MIE]                      = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE]                     = mstatus_mpie_q;
    mstatus_val[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
    mie_val                                       = '0;
    mie_val[MIE_MEIE]                             = mie_meie_q;
    mip_val                                       = '0;
    mip_val[MIP_MEIP]                             = ext_irq;
  end

  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_old = mstatus_val;
      CSR_MIE:      csr_old = mie_val;
      CSR_MTVEC:    csr_old = mtvec_q;
      CSR_MSCRATCH: csr_old = mscratch_q;
      CSR_MEPC:     csr_old = mepc_q;
      CSR_MCAUSE:   csr_old = mcause_q;
      CSR_MIP:      csr_old = mip_val;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE:   csr_old = XLEN'(cnt_value);
      CSR_MCYCLEH: begin
        // The high half only exists as a separate CSR on 32-bit cores.
        if (XLEN == 32) csr_old = XLEN'(cnt_value >> 32);
        else            csr_hit = 1'b0;
      end
`endif
      default:      csr_hit = 1'b0;
    endcase
  end

  assign illegal    = (op != CsrOpNone) && !csr_hit;
  assign csr_rdata  = ((op != CsrOpNone) && csr_hit) ? csr_old : '0;
  assign irq_pend   = mstatus_mie_q && mie_meie_q && ext_irq;
  assign trap_taken = !illegal && (ecall || irq_pend);
  assign mret_taken = !illegal && !trap_taken && mret;
  assign redirect   = trap_taken || mret_taken;
  assign redirect_pc = trap_taken ? mtvec_q : mepc_q;

  // Any higher-priority event (trap or mret) suppresses the CSR write.
  assign csr_we = csr_hit && !trap_taken && !mret && csr_op_writes(op, csr_wdata == '0);

  always_comb begin
    wr_val = csr_old;
    unique case (op)
      CsrOpRw: wr_val = csr_wdata;
      CsrOpRs: wr_val = csr_old | csr_wdata;
      CsrOpRc: wr_val = csr_old & ~csr_wdata;
      default: wr_val = csr_old;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wr_val[MSTATUS_MIE];
          mstatus_mpie_d = wr_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_meie_d = wr_val[MIE_MEIE];
        CSR_MTVEC:    mtvec_d    = {wr_val[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = {wr_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wr_val;
        default: ;
      endcase
    end
    if (trap_taken) begin
      mepc_d         = {pc[XLEN-1:2], 2'b00};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      if (ecall) begin
        mcause_d = XLEN'(CAUSE_ECALL_M);
      end else begin
        mcause_d           = XLEN'(CAUSE_IRQ_EXT_M);
        mcause_d[XLEN-1]   = 1'b1;
      end
    end else if (mret_taken) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

`ifdef CSR_MCYCLE_EN
  assign cnt_wr_lo = csr_we && (csr_addr == CSR_MCYCLE);
  assign cnt_wr_hi = csr_we && (csr_addr == CSR_MCYCLEH);

  ysyx_23060240_csr_counter #(
    .XLEN (XLEN)
  ) u_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_lo_i (cnt_wr_lo),
    .wr_hi_i (cnt_wr_hi),
    .wdata_i (csr_wdata),
    .value_o (cnt_value)
  );
`endif

endmodule

// File: tb/tb_ysyx_23060240_csr_trap.sv
// Self-checking bench: directed vector table, reset/counter sequences, random vs. reference model.
module tb_ysyx_23060240_csr_trap;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        ecall, mret, ext_irq, trap_taken, redirect, illegal;

  ysyx_23060240_csr_trap #(
    .XLEN        (32),
    .MTVEC_RESET (MTVEC_RST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .ecall       (ecall),
    .mret        (mret),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .trap_taken  (trap_taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        ec, mr, irq;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        trap, redir;
    logic [31:0] rpc;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  // Reference model state, held as whole architectural register values.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [11:0] addrs[7] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input logic ec, input logic mr, input logic irq, input logic [31:0] p);
    @(negedge clk);
    csr_addr = a; csr_op = op; csr_wdata = wd; ecall = ec; mret = mr; ext_irq = irq; pc = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    csr_addr = '0; csr_op = 2'b00; csr_wdata = '0; ecall = 0; mret = 0; ext_irq = 0; pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic [11:0] a, logic [1:0] op, logic [31:0] wd, logic ec,
                              logic mr, logic irq, logic [31:0] p, logic [31:0] rd,
                              logic tr, logic rdr, logic [31:0] rpc, logic ill);
    vec_t v;
    v.addr = a; v.op = op; v.wdata = wd; v.ec = ec; v.mr = mr; v.irq = irq; v.pc = p;
    v.rdata = rd; v.trap = tr; v.redir = rdr; v.rpc = rpc; v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] mdl_read(logic [11:0] a, logic irq);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return irq ? 32'h800 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

`ifdef CSR_MCYCLE_EN
  task automatic counter_seq(input bit hi_first);
    drive(12'hB00, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 0);
    drive(12'hB80, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 0);
    drive(12'h000, 2'b00, 32'h0, 0, 0, 0, 0);
    drive(hi_first ? 12'hB80 : 12'hB00, 2'b10, 32'h0, 0, 0, 0, 0);
    #1 check(hi_first ? "mcycleh_wrap" : "mcycle_wrap", csr_rdata, 32'h0);
    drive(hi_first ? 12'hB00 : 12'hB80, 2'b10, 32'h0, 0, 0, 0, 0);
    #1 check(hi_first ? "mcycle_after_wrap" : "mcycleh_after_wrap", csr_rdata,
             hi_first ? 32'h1 : 32'h0);
  endtask
`endif

  initial begin
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] wd, p, old, nv;
    logic        ec, mr, irq, pend, trap, redir;

    tbl.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    tbl.push_back(mk(12'h305, 2'b10, 32'h0, 0, 0, 0, 0, MTVEC_RST, 0, 0, 0, 0));
    tbl.push_back(mk(12'h305, 2'b01, 32'h8000_0103, 0, 0, 0, 0, MTVEC_RST, 0, 0, 0, 0));
    tbl.push_back(mk(12'h305, 2'b10, 32'h0, 0, 0, 0, 0, 32'h8000_0100, 0, 0, 0, 0));
    tbl.push_back(mk(12'h300, 2'b10, 32'h8, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    tbl.push_back(mk(12'h000, 2'b00, 32'h0, 1, 0, 0, 32'h8000_0010, 32'h0, 1, 1, 32'h8000_0100, 0));
    tbl.push_back(mk(12'h341, 2'b10, 32'h0, 0, 0, 0, 0, 32'h8000_0010, 0, 0, 0, 0));
    tbl.push_back(mk(12'h342, 2'b10, 32'h0, 0, 0, 0, 0, 32'd11, 0, 0, 0, 0));
    tbl.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 32'h1880, 0, 0, 0, 0));
    tbl.push_back(mk(12'h000, 2'b00, 32'h0, 0, 1, 0, 0, 32'h0, 0, 1, 32'h8000_0010, 0));
    tbl.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 32'h1888, 0, 0, 0, 0));
    tbl.push_back(mk(12'h304, 2'b10, 32'h800, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(12'h340, 2'b01, 32'h5, 0, 0, 1, 32'h8000_0020, 32'h0, 1, 1, 32'h8000_0100, 0));
    tbl.push_back(mk(12'h342, 2'b10, 32'h0, 0, 0, 0, 0, 32'h8000_000B, 0, 0, 0, 0));
    tbl.push_back(mk(12'h340, 2'b10, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 32'h1880, 0, 0, 0, 0));
    tbl.push_back(mk(12'h7C0, 2'b01, 32'hFFFF, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(12'h344, 2'b10, 32'h0, 0, 0, 1, 0, 32'h800, 0, 0, 0, 0));
    tbl.push_back(mk(12'h341, 2'b01, 32'h1234_5677, 0, 0, 0, 0, 32'h8000_0020, 0, 0, 0, 0));
    tbl.push_back(mk(12'h341, 2'b10, 32'h0, 0, 0, 0, 0, 32'h1234_5674, 0, 0, 0, 0));
    tbl.push_back(mk(12'h300, 2'b11, 32'h80, 0, 0, 0, 0, 32'h1880, 0, 0, 0, 0));
    tbl.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    tbl.push_back(mk(12'h7C0, 2'b00, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
`ifndef CSR_MCYCLE_EN
    tbl.push_back(mk(12'hB00, 2'b10, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(12'hB80, 2'b01, 32'h1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));
`endif

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].addr, tbl[i].op, tbl[i].wdata, tbl[i].ec, tbl[i].mr, tbl[i].irq, tbl[i].pc);
      #1;
      check($sformatf("v%0d_rdata", i), csr_rdata, tbl[i].rdata);
      check($sformatf("v%0d_trap", i), 32'(trap_taken), 32'(tbl[i].trap));
      check($sformatf("v%0d_redirect", i), 32'(redirect), 32'(tbl[i].redir));
      check($sformatf("v%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
      if (tbl[i].redir) check($sformatf("v%0d_rpc", i), redirect_pc, tbl[i].rpc);
    end

    // Reset must win over a simultaneous ecall and CSR write.
    drive(12'h300, 2'b10, 32'h8, 0, 0, 0, 0);
    drive(12'h340, 2'b01, 32'hAA, 1, 0, 0, 32'h1000);
    rst = 1'b1;
    drive(12'h300, 2'b10, 32'h0, 0, 0, 0, 0);
    #1 check("rst_mstatus", csr_rdata, 32'h1800);
    rst = 1'b0;
    drive(12'h341, 2'b10, 32'h0, 0, 0, 0, 0);
    #1 check("rst_mepc", csr_rdata, 32'h0);
    drive(12'h340, 2'b10, 32'h0, 0, 0, 0, 0);
    #1 check("rst_mscratch", csr_rdata, 32'h0);
    drive(12'h305, 2'b10, 32'h0, 0, 0, 0, 0);
    #1 check("rst_mtvec", csr_rdata, MTVEC_RST);

`ifdef CSR_MCYCLE_EN
    counter_seq(1'b0);
    counter_seq(1'b1);
`endif

    do_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    for (int i = 0; i < 400; i++) begin
      a   = addrs[$urandom_range(0, 6)];
      op  = 2'($urandom_range(0, 3));
      wd  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      ec  = ($urandom_range(0, 7) == 0);
      mr  = ($urandom_range(0, 5) == 0);
      irq = 1'($urandom_range(0, 1));
      p   = $urandom;
      drive(a, op, wd, ec, mr, irq, p);
      #1;
      old   = mdl_read(a, irq);
      pend  = m_mstatus[3] & m_mie[11] & irq;
      trap  = ec | pend;
      redir = trap | mr;
      check($sformatf("r%0d_rdata", i), csr_rdata, (op != 2'b00) ? old : 32'h0);
      check($sformatf("r%0d_trap", i), 32'(trap_taken), 32'(trap));
      check($sformatf("r%0d_redirect", i), 32'(redirect), 32'(redir));
      check($sformatf("r%0d_illegal", i), 32'(illegal), 32'h0);
      if (redir) check($sformatf("r%0d_rpc", i), redirect_pc, trap ? m_mtvec : m_mepc);
      if (trap) begin
        m_mepc    = p & 32'hFFFF_FFFC;
        m_mcause  = ec ? 32'd11 : 32'h8000_000B;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (mr) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (op == 2'b01 || (op != 2'b00 && wd != 0)) begin
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        case (a)
          12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
          12'h304: m_mie      = nv & 32'h800;
          12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
          12'h342: m_mcause   = nv;
          default: ;
        endcase
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
